// File: rtl/seg_scan_decoder.sv
// Recovers the BCD value shown on a multiplexed 4-digit 7-segment display by
// sampling its anode/segment drive, debouncing each slot and assembling frames.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  anode,
    input  logic [7:0]  eSeg,
    output logic [15:0] num,
    output logic [3:0]  dp,
    output logic        num_valid,
    output logic        seg_err,
    output logic        frame_err
);

    localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        SYNC,
        COLLECT
    } state_t;

    logic [3:0]  anode_q;
    logic [7:0]  eseg_q;
    logic [11:0] prev_q;
    logic [7:0]  cnt_q;

    state_t      state_q, state_d;
    logic [1:0]  exp_q, exp_d;
    logic [11:0] shadow_num_q, shadow_num_d;
    logic [2:0]  shadow_dp_q, shadow_dp_d;
    logic [15:0] num_d;
    logic [3:0]  dp_d;
    logic        num_valid_d, seg_err_d, frame_err_d;

    logic        anode_valid;
    logic [1:0]  digit_idx;
    logic        digit_ok;
    logic [3:0]  digit_bcd;
    logic        pair_changed;
    logic        commit;

    // The display pins are asynchronous to us: everything downstream sees only
    // this registered copy, and prev_q holds the sample before it.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement or process order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            anode_q <= 4'b1111;
            eseg_q  <= 8'h00;
            prev_q  <= {4'b1111, 8'h00};
        end else begin
            anode_q <= anode;
            eseg_q  <= eSeg;
            prev_q  <= {anode_q, eseg_q};
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        anode_valid = 1'b1;
        digit_idx   = 2'd0;
        case (anode_q)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: anode_valid = 1'b0;
        endcase
    end

    always_comb begin
        digit_ok  = 1'b1;
        digit_bcd = 4'd0;
        case (eseg_q[6:0])
            7'b0111111: digit_bcd = 4'd0;
            7'b0000110: digit_bcd = 4'd1;
            7'b1011011: digit_bcd = 4'd2;
            7'b1001111: digit_bcd = 4'd3;
            7'b1100110: digit_bcd = 4'd4;
            7'b1101101: digit_bcd = 4'd5;
            7'b1111101: digit_bcd = 4'd6;
            7'b0000111: digit_bcd = 4'd7;
            7'b1111111: digit_bcd = 4'd8;
            7'b1101111: digit_bcd = 4'd9;
            default:    digit_ok  = 1'b0;
        endcase
    end

    assign pair_changed = ({anode_q, eseg_q} != prev_q);
    // Fires only on the single edge the counter climbs to STABLE_CYCLES, so a
    // slot held longer saturates without recommitting.
    assign commit = anode_valid && !pair_changed && (cnt_q == CNT_COMMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else if (!anode_valid) begin
            cnt_q <= 8'd0;
        end else if (pair_changed) begin
            cnt_q <= 8'd1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= SYNC;
            exp_q        <= 2'd0;
            shadow_num_q <= 12'h000;
            shadow_dp_q  <= 3'b000;
            num          <= 16'h0000;
            dp           <= 4'b0000;
            num_valid    <= 1'b0;
            seg_err      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            shadow_num_q <= shadow_num_d;
            shadow_dp_q  <= shadow_dp_d;
            num          <= num_d;
            dp           <= dp_d;
            num_valid    <= num_valid_d;
            seg_err      <= seg_err_d;
            frame_err    <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        shadow_num_d = shadow_num_q;
        shadow_dp_d  = shadow_dp_q;
        num_d        = num;
        dp_d         = dp;
        num_valid_d  = 1'b0;
        seg_err_d    = 1'b0;
        frame_err_d  = 1'b0;

        if (commit) begin
            if (!digit_ok) begin
                // Bad segment pattern wins over any ordering problem.
                seg_err_d    = 1'b1;
                state_d      = SYNC;
                exp_d        = 2'd0;
                shadow_num_d = 12'h000;
                shadow_dp_d  = 3'b000;
            end else if (state_q == SYNC) begin
                if (digit_idx == 2'd0) begin
                    shadow_num_d = {8'h00, digit_bcd};
                    shadow_dp_d  = {2'b00, eseg_q[7]};
                    state_d      = COLLECT;
                    exp_d        = 2'd1;
                end
            end else if (digit_idx != exp_q) begin
                frame_err_d  = 1'b1;
                shadow_num_d = 12'h000;
                shadow_dp_d  = 3'b000;
                if (digit_idx == 2'd0) begin
                    shadow_num_d = {8'h00, digit_bcd};
                    shadow_dp_d  = {2'b00, eseg_q[7]};
                    state_d      = COLLECT;
                    exp_d        = 2'd1;
                end else begin
                    state_d = SYNC;
                    exp_d   = 2'd0;
                end
            end else if (digit_idx == 2'd3) begin
                num_d        = {digit_bcd, shadow_num_q};
                dp_d         = {eseg_q[7], shadow_dp_q};
                num_valid_d  = 1'b1;
                state_d      = SYNC;
                exp_d        = 2'd0;
                shadow_num_d = 12'h000;
                shadow_dp_d  = 3'b000;
            end else begin
                case (digit_idx)
                    2'd1:    begin
                                 shadow_num_d[7:4] = digit_bcd;
                                 shadow_dp_d[1]    = eseg_q[7];
                             end
                    default: begin
                                 shadow_num_d[11:8] = digit_bcd;
                                 shadow_dp_d[2]     = eseg_q[7];
                             end
                endcase
                exp_d = 2'(exp_q + 2'd1);
            end
        end
    end

endmodule
